arithmetic_logic_unit: RTL and testbench

// Combinational integer ALU for the mips86 datapath. Takes two WIDTH-bit

---
 rtl/arithmetic_logic_unit.sv | 90 +++++++++
 tb/tb_arithmetic_logic_unit.sv | 114 +++++++++++
 2 files changed

// File: rtl/arithmetic_logic_unit.sv
// arithmetic_logic_unit: combinational integer ALU for the mips86 datapath.
//
// Produces a WIDTH-bit result and a single flag bit from two operands and a
// 4-bit operation select. The flag is the signed-overflow indicator for
// ADD/SUB and the boolean result for EQ/GT/LT. An active-low reset
// asynchronously forces both outputs to zero. No state is held.
//
// Ports (declaration order is relied on by positional instantiation):
//   a        in   WIDTH  operand A (shift/rotate source)
//   b        in   WIDTH  operand B (shift/rotate amount)
//   control  in   4      operation select
//   clk      in   1      system clock, not used by the datapath
//   reset    in   1      async reset, active low; 0 forces out/overflow to 0
//   out      out  WIDTH  result
//   overflow out  1      overflow / compare flag
module arithmetic_logic_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       control,
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] out,
  output logic             overflow
);

  // WIDTH always fits in WIDTH bits for WIDTH >= 2.
  localparam logic [WIDTH-1:0] WidthB = WIDTH[WIDTH-1:0];

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpShl = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpAnd = 4'd4;
  localparam logic [3:0] OpXor = 4'd5;
  localparam logic [3:0] OpRor = 4'd6;
  localparam logic [3:0] OpEq  = 4'd7;
  localparam logic [3:0] OpGt  = 4'd8;
  localparam logic [3:0] OpLt  = 4'd9;

  // The clock is part of the datapath's port contract only.
  logic unused_clk;
  assign unused_clk = clk;

  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   rot_amt;
  logic [2*WIDTH-1:0] rot_wide;
  logic [WIDTH-1:0]   res;
  logic               flag;

  assign sum      = a + b;
  assign diff     = a - b;
  assign rot_amt  = b % WidthB;
  // Shifting a doubled copy right leaves the rotation in the low half.
  assign rot_wide = {a, a} >> rot_amt;

  always_comb begin
    res  = '0;
    flag = 1'b0;
    case (control)
      OpAdd: begin
        res  = sum;
        flag = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub: begin
        res  = diff;
        flag = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OpShl:   res  = (b >= WidthB) ? '0 : (a << b);
      OpOr:    res  = a | b;
      OpAnd:   res  = a & b;
      OpXor:   res  = a ^ b;
      OpRor:   res  = rot_wide[WIDTH-1:0];
      OpEq:    flag = (a == b);
      OpGt:    flag = (a > b);
      OpLt:    flag = (a < b);
      default: begin
        res  = '0;
        flag = 1'b0;
      end
    endcase
  end

  // Reset gates the outputs directly so assertion and release act at once.
  assign out      = reset ? res : '0;
  assign overflow = reset ? flag : 1'b0;

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
// tb_arithmetic_logic_unit: directed-vector bench for arithmetic_logic_unit
// (WIDTH=8) with hand-computed expected results.
module tb_arithmetic_logic_unit;

  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] control;
  logic       clk;
  logic       reset;
  logic [7:0] out;
  logic       overflow;

  int total;
  int bad;

  arithmetic_logic_unit #(
    .WIDTH(8)
  ) dut (
    .a       (a),
    .b       (b),
    .control (control),
    .clk     (clk),
    .reset   (reset),
    .out     (out),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one vector away from the clock edges, then check both outputs.
  task automatic vec(input string tag, input logic [3:0] ctl, input logic [7:0] va,
                     input logic [7:0] vb, input logic [7:0] exp_out, input logic exp_ov);
    @(negedge clk);
    control = ctl;
    a       = va;
    b       = vb;
    #1;
    check({tag, ".out"}, {8'h00, out}, {8'h00, exp_out});
    check({tag, ".ov"}, {15'h0, overflow}, {15'h0, exp_ov});
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b0;
    a       = 8'd5;
    b       = 8'd7;
    control = 4'd0;
    #2;
    check("rst.out", {8'h00, out}, 16'h0000);
    check("rst.ov", {15'h0, overflow}, 16'h0000);
    reset = 1'b1;
    #1;
    check("rel.out", {8'h00, out}, 16'h000C);
    check("rel.ov", {15'h0, overflow}, 16'h0000);

    vec("add_5_7",   4'd0, 8'h05, 8'h07, 8'h0C, 1'b0);
    vec("add_wrap",  4'd0, 8'hFF, 8'h01, 8'h00, 1'b0);
    vec("add_ovf",   4'd0, 8'h7F, 8'h01, 8'h80, 1'b1);
    vec("add_negov", 4'd0, 8'h80, 8'h80, 8'h00, 1'b1);
    vec("sub_5_7",   4'd1, 8'h05, 8'h07, 8'hFE, 1'b0);
    vec("sub_ovf",   4'd1, 8'h80, 8'h01, 8'h7F, 1'b1);
    vec("sub_posov", 4'd1, 8'h7F, 8'hFF, 8'h80, 1'b1);
    vec("shl_1",     4'd2, 8'h05, 8'h01, 8'h0A, 1'b0);
    vec("shl_0",     4'd2, 8'h05, 8'h00, 8'h05, 1'b0);
    vec("shl_7",     4'd2, 8'h03, 8'h07, 8'h80, 1'b0);
    vec("shl_8",     4'd2, 8'h05, 8'h08, 8'h00, 1'b0);
    vec("shl_big",   4'd2, 8'hFF, 8'hFF, 8'h00, 1'b0);
    vec("or",        4'd3, 8'h55, 8'hAA, 8'hFF, 1'b0);
    vec("and",       4'd4, 8'h55, 8'hAA, 8'h00, 1'b0);
    vec("and_mix",   4'd4, 8'hF0, 8'h3C, 8'h30, 1'b0);
    vec("xor",       4'd5, 8'h55, 8'hAB, 8'hFE, 1'b0);
    vec("ror_1",     4'd6, 8'h55, 8'h01, 8'hAA, 1'b0);
    vec("ror_0",     4'd6, 8'h55, 8'h00, 8'h55, 1'b0);
    vec("ror_8",     4'd6, 8'h55, 8'h08, 8'h55, 1'b0);
    vec("ror_3",     4'd6, 8'h01, 8'h03, 8'h20, 1'b0);
    vec("ror_11",    4'd6, 8'h01, 8'h0B, 8'h20, 1'b0);
    vec("eq_t",      4'd7, 8'h55, 8'h55, 8'h00, 1'b1);
    vec("eq_f",      4'd7, 8'h55, 8'h54, 8'h00, 1'b0);
    vec("gt_t",      4'd8, 8'h05, 8'h01, 8'h00, 1'b1);
    vec("gt_uns",    4'd8, 8'h80, 8'h7F, 8'h00, 1'b1);
    vec("gt_f",      4'd8, 8'h7F, 8'h80, 8'h00, 1'b0);
    vec("lt_f",      4'd9, 8'h05, 8'h01, 8'h00, 1'b0);
    vec("lt_t",      4'd9, 8'h01, 8'h05, 8'h00, 1'b1);
    for (int c = 10; c < 16; c++) begin
      vec($sformatf("rsv_%0d", c), 4'(c), 8'hFF, 8'hFF, 8'h00, 1'b0);
    end

    // Reset pulse in the middle of a vector, away from any clock edge.
    vec("mid_pre", 4'd0, 8'h7F, 8'h01, 8'h80, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst.out", {8'h00, out}, 16'h0000);
    check("mid_rst.ov", {15'h0, overflow}, 16'h0000);
    reset = 1'b1;
    #1;
    check("mid_rel.out", {8'h00, out}, 16'h0080);
    check("mid_rel.ov", {15'h0, overflow}, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
